sram_port_arb: RTL and testbench
================================

# sram_port_arb

Arbiter that shares the single synchronous SRAM port of the unified-memory CPU variant between instruction fetch (IF) and data access (MEM). It grants one request per cycle, tracks the one outstanding read, and holds returned read data in a response buffer while the consumer stage is stalled, so ID and WB never lose an instruction or load word. It raises a stall request toward the pipeline control block whenever a requester is waiting.

## Interface
- STARVE_MAX, 4: consecutive IF denials after which IF wins the next contested cycle (1..15).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- if_req  in  1  fetch read request; held until granted.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch issued to SRAM this cycle.
- if_rvalid  out  1  fetch data valid.
- if_rready  in  1  IF/ID can accept data (inverse of stall[1]).
- if_rdata  out  32  fetch data.
- dm_req  in  1  data request; held until granted.
- dm_wen  in  4  byte write enables; 0 means read.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  data request issued this cycle.
- dm_rvalid  out  1  load data valid (reads only).
- dm_rready  in  1  MEM/WB can accept data.
- dm_rdata  out  32  load data.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after an enabled read.
- stallreq_for_mem  out  1  (if_req & ~if_gnt) | (dm_req & ~dm_gnt).

## Operation
- States: IDLE, WAIT_IF, WAIT_DM, HOLD_IF, HOLD_DM.
- Issue allowed in IDLE, or in WAIT_x when the arriving response is accepted this cycle (rready high). Never in HOLD_x.
- Priority when both request and issue allowed: DM wins unless starve counter == STARVE_MAX, then IF wins.
- Starve counter (4 bits): +1 when if_req and DM granted; cleared on if_gnt or when if_req low; saturates at STARVE_MAX.
- Grant drives sram_en=1, sram_addr/wen/wdata from the winner (IF: wen=0); otherwise sram_en=0, sram_wen=0.
- DM write (dm_wen≠0): completes at grant; no response, no state change from IDLE (or returns to IDLE from WAIT_x).
- Read grant → WAIT_IF / WAIT_DM.
- WAIT_x: rvalid_x=1, rdata_x=sram_rdata. If rready_x: go to next state per new grant (IDLE if none). Else latch sram_rdata into resp_buf → HOLD_x.
- HOLD_x: rvalid_x=1, rdata_x=resp_buf; on rready_x → IDLE.
- rdata of the non-valid channel is don't-care; drive resp_buf.

## Timing
- Reset: state IDLE, starve counter 0, resp_buf 0; all outputs 0 except stallreq_for_mem (combinational on requests).
- Grant is combinational in the request cycle; read data valid exactly 1 cycle later at best; back-to-back reads give one word per cycle.
- Latency read-grant → rvalid: 1 cycle; HOLD adds cycles until rready.
- Simultaneous if_req and dm_req in IDLE: dm_gnt=1, if_gnt=0, stallreq_for_mem=1.
- Response accept and new request same cycle: accepted and new issue both happen; no bubble.
- Reset mid-operation: outstanding read and buffered data dropped; requesters must re-request.

## Structure
- State encoding, STARVE_MAX default and bus widths go in lib/defines.vh beside the existing stall/bus widths.
- One sub-module is natural: sram_resp_buf (32-bit capture register + valid, load on WAIT & ~rready, clear on accept).

## Test plan
- Reset: rst=0 for 2 cycles with if_req=1 → all grants/valids 0, state IDLE; release → if_gnt=1 same cycle.
- IF stream: if_req=1, addrs 0x0,0x4,0x8, if_rready=1, sram returns 0xA,0xB,0xC → if_rvalid three consecutive cycles with 0xA,0xB,0xC.
- Contention: both requests held, dm_wen=0, STARVE_MAX=4 → DM granted 4 cycles, IF granted 5th, counter clears.
- Stall hold: IF read granted, if_rready=0 for 3 cycles, sram_rdata changes to 0xDEAD after capture → if_rdata stays original 0x1234 until rready, no grant while holding.
- Store: dm_req, dm_wen=4'b1111, addr 0x100, data 0x55 → sram_wen=1111 that cycle, dm_rvalid never asserted, IF granted next cycle.
- Reset during HOLD_DM → next cycle dm_rvalid=0, state IDLE.

Source files
------------

// File: rtl/sram_port_arb_pkg.sv
// Shared types and constants for the unified-memory SRAM port arbiter.
//
// Contents:
//   AddrW / DataW / WenW   bus widths of the fetch, data and SRAM ports
//   CntW                   width of the IF starvation counter
//   StarveMaxDefault       default consecutive-denial limit for IF
//   arb_state_e            arbiter FSM states
//   is_write()             true when a data request carries any byte enable
package sram_port_arb_pkg;

    localparam int unsigned AddrW            = 32;
    localparam int unsigned DataW            = 32;
    localparam int unsigned WenW             = 4;
    localparam int unsigned CntW             = 4;
    localparam int unsigned StarveMaxDefault = 4;

    // WAIT_x: a read was issued last cycle and its data is on sram_rdata now.
    // HOLD_x: that data was not accepted and sits in the response buffer.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitIf = 3'd1,
        StWaitDm = 3'd2,
        StHoldIf = 3'd3,
        StHoldDm = 3'd4
    } arb_state_e;

    function automatic logic is_write(input logic [WenW-1:0] wen);
        return wen != '0;
    endfunction

endpackage

// File: rtl/sram_port_arb_if.sv
// Handshake bundle between the pipeline requesters (IF, MEM), the arbiter
// and the single synchronous SRAM port.
//
// Signals:
//   if_*        fetch request / grant / read response
//   dm_*        data request / grant / load response
//   sram_*      SRAM command (en/wen/addr/wdata) and read data
//   stallreq_for_mem  a requester is waiting this cycle
// Modports:
//   slave   the arbiter side
//   master  the requester / SRAM model side
interface sram_port_arb_if;
    import sram_port_arb_pkg::*;

    logic             if_req;
    logic [AddrW-1:0] if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic             if_rready;
    logic [DataW-1:0] if_rdata;

    logic             dm_req;
    logic [WenW-1:0]  dm_wen;
    logic [AddrW-1:0] dm_addr;
    logic [DataW-1:0] dm_wdata;
    logic             dm_gnt;
    logic             dm_rvalid;
    logic             dm_rready;
    logic [DataW-1:0] dm_rdata;

    logic             sram_en;
    logic [WenW-1:0]  sram_wen;
    logic [AddrW-1:0] sram_addr;
    logic [DataW-1:0] sram_wdata;
    logic [DataW-1:0] sram_rdata;

    logic             stallreq_for_mem;

    modport slave (
        input  if_req, if_addr, if_rready,
        input  dm_req, dm_wen, dm_addr, dm_wdata, dm_rready,
        input  sram_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        output stallreq_for_mem
    );

    modport master (
        output if_req, if_addr, if_rready,
        output dm_req, dm_wen, dm_addr, dm_wdata, dm_rready,
        output sram_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        input  stallreq_for_mem
    );

endinterface

// File: rtl/sram_port_arb_resp_buf.sv
// Response buffer: captures a read word that the consumer stage could not
// accept in the cycle it arrived, and holds it until accepted.
//
// Ports:
//   clk    clock
//   rst    synchronous reset, active-low
//   load   capture din (arriving word not accepted)
//   clr    held word accepted; drop valid
//   din    SRAM read data
//   dout   buffered word
//   valid  dout holds an unconsumed word
module sram_port_arb_resp_buf
    import sram_port_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr,
    input  logic [DataW-1:0] din,
    output logic [DataW-1:0] dout,
    output logic             valid
);

    logic [DataW-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end else if (clr) begin
            // Data is left in place; it is only a don't-care after accept.
            valid_q <= 1'b0;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/sram_port_arb.sv
// Arbiter sharing the single synchronous SRAM port between instruction fetch
// (IF) and data access (MEM). One request is issued per cycle, the single
// outstanding read is tracked, and an unaccepted read word is parked in a
// response buffer until its consumer stage un-stalls.
//
// Parameters:
//   STARVE_MAX  consecutive IF denials after which IF wins a contested cycle
// Ports:
//   clk   clock
//   rst   synchronous reset, active-low
//   bus   requester/SRAM bundle (slave side): grants are combinational in the
//         request cycle, read data is presented the following cycle.
module sram_port_arb
    import sram_port_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic            clk,
    input  logic            rst,
    sram_port_arb_if.slave  bus
);

    arb_state_e       state_q, state_d;
    arb_state_e       issue_state;
    logic [CntW-1:0]  starve_q, starve_d;

    logic             issue_ok;
    logic             starved;
    logic             dm_win;
    logic             if_win;
    logic             buf_load;
    logic             buf_clr;
    logic             buf_valid;
    logic [DataW-1:0] buf_data;

    // ---------------------------------------------------------------- issue
    always_comb begin
        // A new access may go out only when the port has no response pending,
        // or the pending response is being consumed this very cycle.
        issue_ok = rst & ((state_q == StIdle) |
                          ((state_q == StWaitIf) & bus.if_rready) |
                          ((state_q == StWaitDm) & bus.dm_rready));
        starved  = starve_q == CntW'(STARVE_MAX);
        dm_win   = issue_ok & bus.dm_req & ~(bus.if_req & starved);
        if_win   = issue_ok & bus.if_req & ~dm_win;

        issue_state = StIdle;
        if (if_win) begin
            issue_state = StWaitIf;
        end else if (dm_win && !is_write(bus.dm_wen)) begin
            issue_state = StWaitDm;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = issue_state;
            StWaitIf: state_d = bus.if_rready ? issue_state : StHoldIf;
            StWaitDm: state_d = bus.dm_rready ? issue_state : StHoldDm;
            StHoldIf: if (bus.if_rready) state_d = StIdle;
            StHoldDm: if (bus.dm_rready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        starve_d = starve_q;
        if (!bus.if_req || if_win) begin
            starve_d = '0;
        end else if (dm_win && !starved) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // -------------------------------------------------------- response buffer
    always_comb begin
        buf_load = ((state_q == StWaitIf) & ~bus.if_rready) |
                   ((state_q == StWaitDm) & ~bus.dm_rready);
        buf_clr  = ((state_q == StHoldIf) & bus.if_rready) |
                   ((state_q == StHoldDm) & bus.dm_rready);
    end

    sram_port_arb_resp_buf u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clr   (buf_clr),
        .din   (bus.sram_rdata),
        .dout  (buf_data),
        .valid (buf_valid)
    );

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.if_gnt     = if_win;
        bus.dm_gnt     = dm_win;

        bus.sram_en    = if_win | dm_win;
        bus.sram_wen   = dm_win ? bus.dm_wen : '0;
        bus.sram_addr  = dm_win ? bus.dm_addr : (if_win ? bus.if_addr : '0);
        bus.sram_wdata = dm_win ? bus.dm_wdata : '0;

        bus.if_rvalid  = rst & ((state_q == StWaitIf) |
                                ((state_q == StHoldIf) & buf_valid));
        bus.dm_rvalid  = rst & ((state_q == StWaitDm) |
                                ((state_q == StHoldDm) & buf_valid));
        bus.if_rdata   = (state_q == StWaitIf) ? bus.sram_rdata : buf_data;
        bus.dm_rdata   = (state_q == StWaitDm) ? bus.sram_rdata : buf_data;

        bus.stallreq_for_mem = (bus.if_req & ~if_win) | (bus.dm_req & ~dm_win);
    end

endmodule

// File: tb/tb_sram_port_arb.sv
`timescale 1ns / 1ps
module tb_sram_port_arb;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sram_port_arb_if bus ();

    sram_port_arb #(
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here and
    // outputs are sampled one step later, well clear of either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst            = 1'b0;
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h0;
        bus.if_rready  = 1'b1;
        bus.dm_req     = 1'b0;
        bus.dm_wen     = 4'h0;
        bus.dm_addr    = 32'h0;
        bus.dm_wdata   = 32'h0;
        bus.dm_rready  = 1'b1;
        bus.sram_rdata = 32'h0;

        // ---- reset held two cycles with if_req high
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            check_eq("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
            check_eq("rst_dm_gnt", 32'(bus.dm_gnt), 32'd0);
            check_eq("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
            check_eq("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
            check_eq("rst_sram_en", 32'(bus.sram_en), 32'd0);
            check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
            check_eq("rst_stallreq", 32'(bus.stallreq_for_mem), 32'd1);
        end

        // ---- release: IF granted in the same cycle, then an IF stream
        tick();
        rst = 1'b1;
        settle();
        check_eq("rel_if_gnt", 32'(bus.if_gnt), 32'd1);
        check_eq("rel_sram_addr", bus.sram_addr, 32'h0);
        check_eq("rel_sram_wen", 32'(bus.sram_wen), 32'd0);
        check_eq("rel_stallreq", 32'(bus.stallreq_for_mem), 32'd0);

        tick();
        bus.if_addr = 32'h4; bus.sram_rdata = 32'hA;
        settle();
        check_eq("str0_rvalid", 32'(bus.if_rvalid), 32'd1);
        check_eq("str0_rdata", bus.if_rdata, 32'hA);
        check_eq("str0_gnt", 32'(bus.if_gnt), 32'd1);
        check_eq("str0_addr", bus.sram_addr, 32'h4);

        tick();
        bus.if_addr = 32'h8; bus.sram_rdata = 32'hB;
        settle();
        check_eq("str1_rvalid", 32'(bus.if_rvalid), 32'd1);
        check_eq("str1_rdata", bus.if_rdata, 32'hB);
        check_eq("str1_addr", bus.sram_addr, 32'h8);

        tick();
        bus.if_req = 1'b0; bus.sram_rdata = 32'hC;
        settle();
        check_eq("str2_rvalid", 32'(bus.if_rvalid), 32'd1);
        check_eq("str2_rdata", bus.if_rdata, 32'hC);
        check_eq("str2_gnt", 32'(bus.if_gnt), 32'd0);

        tick();
        settle();
        check_eq("str_end_rvalid", 32'(bus.if_rvalid), 32'd0);

        // ---- contention: DM wins four times, IF on the fifth, then DM again
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.dm_req = 1'b1; bus.dm_wen = 4'h0; bus.dm_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("cont_dm_gnt", 32'(bus.dm_gnt), 32'd1);
            check_eq("cont_if_gnt", 32'(bus.if_gnt), 32'd0);
            check_eq("cont_stallreq", 32'(bus.stallreq_for_mem), 32'd1);
            check_eq("cont_dm_rvalid", 32'(bus.dm_rvalid), (k == 0) ? 32'd0 : 32'd1);
            tick();
        end
        settle();
        check_eq("starve_if_gnt", 32'(bus.if_gnt), 32'd1);
        check_eq("starve_dm_gnt", 32'(bus.dm_gnt), 32'd0);
        check_eq("starve_addr", bus.sram_addr, 32'h10);
        tick();
        settle();
        check_eq("clr_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        check_eq("clr_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        tick();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        settle();
        check_eq("cont_tail_rvalid", 32'(bus.dm_rvalid), 32'd1);
        check_eq("cont_tail_en", 32'(bus.sram_en), 32'd0);
        tick();

        // ---- stall hold on IF with a pending DM request
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'h40; bus.if_rready = 1'b0;
        settle();
        check_eq("hold_gnt", 32'(bus.if_gnt), 32'd1);
        tick();
        bus.if_req = 1'b0; bus.sram_rdata = 32'h1234;
        bus.dm_req = 1'b1; bus.dm_wen = 4'h0; bus.dm_addr = 32'h280;
        settle();
        check_eq("hold_wait_rvalid", 32'(bus.if_rvalid), 32'd1);
        check_eq("hold_wait_rdata", bus.if_rdata, 32'h1234);
        check_eq("hold_wait_dm_gnt", 32'(bus.dm_gnt), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            bus.sram_rdata = 32'hDEAD;
            settle();
            check_eq("hold_rdata", bus.if_rdata, 32'h1234);
            check_eq("hold_rvalid", 32'(bus.if_rvalid), 32'd1);
            check_eq("hold_dm_gnt", 32'(bus.dm_gnt), 32'd0);
            check_eq("hold_stallreq", 32'(bus.stallreq_for_mem), 32'd1);
        end
        tick();
        bus.if_rready = 1'b1;
        settle();
        check_eq("hold_acc_rdata", bus.if_rdata, 32'h1234);
        check_eq("hold_acc_dm_gnt", 32'(bus.dm_gnt), 32'd0);
        tick();
        settle();
        check_eq("post_hold_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        check_eq("post_hold_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        tick();
        bus.dm_req = 1'b0; bus.sram_rdata = 32'h77;
        settle();
        check_eq("post_hold_dm_rdata", bus.dm_rdata, 32'h77);
        tick();

        // ---- store: no response, IF granted next cycle
        tick();
        bus.dm_req = 1'b1; bus.dm_wen = 4'hF; bus.dm_addr = 32'h100; bus.dm_wdata = 32'h55;
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        settle();
        check_eq("st_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        check_eq("st_if_gnt", 32'(bus.if_gnt), 32'd0);
        check_eq("st_sram_wen", 32'(bus.sram_wen), 32'hF);
        check_eq("st_sram_addr", bus.sram_addr, 32'h100);
        check_eq("st_sram_wdata", bus.sram_wdata, 32'h55);
        tick();
        bus.dm_req = 1'b0; bus.dm_wen = 4'h0;
        settle();
        check_eq("st_no_rvalid", 32'(bus.dm_rvalid), 32'd0);
        check_eq("st_next_if_gnt", 32'(bus.if_gnt), 32'd1);
        check_eq("st_next_addr", bus.sram_addr, 32'h80);
        tick();
        bus.if_req = 1'b0;
        settle();
        check_eq("st_if_rvalid", 32'(bus.if_rvalid), 32'd1);
        tick();

        // ---- reset while holding a DM load
        tick();
        bus.dm_req = 1'b1; bus.dm_addr = 32'h300; bus.dm_rready = 1'b0;
        settle();
        check_eq("rh_dm_gnt", 32'(bus.dm_gnt), 32'd1);
        tick();
        bus.dm_req = 1'b0; bus.sram_rdata = 32'h99;
        settle();
        check_eq("rh_wait_rvalid", 32'(bus.dm_rvalid), 32'd1);
        tick();
        bus.sram_rdata = 32'h0;
        settle();
        check_eq("rh_hold_rvalid", 32'(bus.dm_rvalid), 32'd1);
        check_eq("rh_hold_rdata", bus.dm_rdata, 32'h99);
        rst = 1'b0;
        tick();
        settle();
        check_eq("rh_rst_rvalid", 32'(bus.dm_rvalid), 32'd0);
        check_eq("rh_rst_rdata", bus.dm_rdata, 32'h0);
        rst = 1'b1;
        tick();
        settle();
        check_eq("rh_after_rvalid", 32'(bus.dm_rvalid), 32'd0);
        check_eq("rh_after_en", 32'(bus.sram_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
